// File: rtl/deser_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
package deser_pkg;

  localparam int DESER_WIDTH_DEF = 8;

  // Width of a counter that holds 0..width-1 bits.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  typedef logic [cnt_w(DESER_WIDTH_DEF)-1:0] cnt_t;

endpackage

// File: rtl/sipo_deser_if.sv
// Bit-stream input and word output handshakes of the deserializer.
// master: upstream bit source plus downstream word sink; slave: the deserializer.
interface sipo_deser_if import deser_pkg::*; #(
  parameter int WIDTH = DESER_WIDTH_DEF
) ();

  logic                    bit_in;
  logic                    bit_valid;
  logic                    bit_ready;
  logic                    sync_clr;
  logic [WIDTH-1:0]        word_out;
  logic                    word_valid;
  logic                    word_ready;
  logic [cnt_w(WIDTH)-1:0] bit_count;
  logic                    drop;

  modport master (
    output bit_in, bit_valid, sync_clr, word_ready,
    input  bit_ready, word_out, word_valid, bit_count, drop
  );

  modport slave (
    input  bit_in, bit_valid, sync_clr, word_ready,
    output bit_ready, word_out, word_valid, bit_count, drop
  );

endinterface

// File: rtl/deser_out_reg.sv
// Output holding register: keeps one assembled word until downstream takes it.
module deser_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  // Load wins over drain so a word completing during delivery keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: accumulates WIDTH bits, then hands the
// word to a holding register with valid/ready; backpressure stalls only the
// last bit of the next word.
module sipo_deser import deser_pkg::*; #(
  parameter int WIDTH     = DESER_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  sipo_deser_if.slave bus
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_p0;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    cnt_p0;
  logic             drop_p1;
  logic [WIDTH-1:0] word_p1;
  logic             vld_p1;
  logic             at_last;
  logic             ready;
  logic             accept;
  logic             complete;

  if (MSB_FIRST) begin : g_msb
    assign shift_next = {shift_p0[WIDTH-2:0], bus.bit_in};
  end else begin : g_lsb
    assign shift_next = {bus.bit_in, shift_p0[WIDTH-1:1]};
  end

  // The only bit that can be refused is the one that would need the busy holding register.
  assign at_last  = (cnt_p0 == LAST);
  assign ready    = !(at_last && vld_p1 && !bus.word_ready);
  assign accept   = bus.bit_valid && ready && !bus.sync_clr;
  assign complete = accept && at_last;

  // Stage p0: shift register and bit counter; sync_clr discards any bit in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_p0 <= '0;
      cnt_p0   <= '0;
      drop_p1  <= 1'b0;
    end else begin
      drop_p1 <= bus.sync_clr && (cnt_p0 != '0);
      if (bus.sync_clr) begin
        shift_p0 <= '0;
        cnt_p0   <= '0;
      end else if (accept) begin
        if (at_last) begin
          shift_p0 <= '0;
          cnt_p0   <= '0;
        end else begin
          shift_p0 <= shift_next;
          cnt_p0   <= cnt_p0 + CW'(1);
        end
      end
    end
  end

  // Stage p1: completed word held for the downstream handshake.
  deser_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (complete),
    .din   (shift_next),
    .ready (bus.word_ready),
    .dout  (word_p1),
    .valid (vld_p1)
  );

  assign bus.bit_ready  = ready;
  assign bus.bit_count  = cnt_p0;
  assign bus.word_out   = word_p1;
  assign bus.word_valid = vld_p1;
  assign bus.drop       = drop_p1;

endmodule
